// File: rtl/alu_issue_stage.sv
// Sequential issue/capture front-end for the 32-bit combinational ALU:
// decodes and holds operands for EXEC_CYCLES, then presents a registered result.
module alu_issue_stage #(
  parameter int unsigned EXEC_CYCLES = 1,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [31:0]      in_a,
  input  logic [31:0]      in_b,
  output logic [31:0]      alu_a,
  output logic [31:0]      alu_b,
  output logic             alu_s1,
  output logic             alu_s2,
  output logic             alu_sub,
  output logic             alu_cin,
  input  logic [31:0]      alu_f,
  input  logic             alu_cout,
  input  logic             alu_set,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_result,
  output logic             out_zero,
  output logic             out_cout,
  output logic             out_err,
  output logic [CNT_W-1:0] op_count
);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_e;

  state_e            state_q, state_d;
  logic [3:0]        exec_cnt_q, exec_cnt_d;
  logic [31:0]       alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic              s1_q, s1_d, s2_q, s2_d, sub_q, sub_d;
  logic [31:0]       res_q, res_d;
  logic              zero_q, zero_d, cout_q, cout_d, err_q, err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic        op_legal;
  logic        is_slt;
  logic [31:0] cap_res;

  assign op_legal = (in_op == 3'b000) || (in_op == 3'b010) || (in_op == 3'b100) ||
                    (in_op == 3'b101) || (in_op == 3'b111);
  // s1 and s2 are both set only by SLT among the legal opcodes
  assign is_slt  = s1_q & s2_q;
  assign cap_res = is_slt ? {31'b0, alu_set} : alu_f;

  always_comb begin
    state_d    = state_q;
    exec_cnt_d = exec_cnt_q;
    alu_a_d    = alu_a_q;
    alu_b_d    = alu_b_q;
    s1_d       = s1_q;
    s2_d       = s2_q;
    sub_d      = sub_q;
    res_d      = res_q;
    zero_d     = zero_q;
    cout_d     = cout_q;
    err_d      = err_q;
    cnt_d      = cnt_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (op_legal) begin
            alu_a_d    = in_a;
            alu_b_d    = in_b;
            s1_d       = in_op[2];
            s2_d       = in_op[1];
            sub_d      = in_op[0];
            exec_cnt_d = 4'(EXEC_CYCLES - 1);
            state_d    = EXEC;
          end else begin
            res_d   = '0;
            zero_d  = 1'b1;
            cout_d  = 1'b0;
            err_d   = 1'b1;
            state_d = DONE;
          end
        end
      end
      EXEC: begin
        if (exec_cnt_q != 4'd0) begin
          exec_cnt_d = exec_cnt_q - 4'd1;
        end else begin
          res_d   = cap_res;
          zero_d  = (cap_res == '0);
          cout_d  = is_slt ? 1'b0 : alu_cout;
          err_d   = 1'b0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      exec_cnt_q <= '0;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      s1_q       <= 1'b0;
      s2_q       <= 1'b0;
      sub_q      <= 1'b0;
      res_q      <= '0;
      zero_q     <= 1'b0;
      cout_q     <= 1'b0;
      err_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      exec_cnt_q <= exec_cnt_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      s1_q       <= s1_d;
      s2_q       <= s2_d;
      sub_q      <= sub_d;
      res_q      <= res_d;
      zero_q     <= zero_d;
      cout_q     <= cout_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
    end
  end

  assign in_ready   = (state_q == IDLE);
  assign out_valid  = (state_q == DONE);
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_s1     = s1_q;
  assign alu_s2     = s2_q;
  assign alu_sub    = sub_q;
  assign alu_cin    = 1'b0;
  assign out_result = res_q;
  assign out_zero   = zero_q;
  assign out_cout   = cout_q;
  assign out_err    = err_q;
  assign op_count   = cnt_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: two instances (EXEC_CYCLES 1 and 4), each driving a
// behavioural ALU stub; results checked against an opcode-level reference model.
module tb_alu_issue_stage;

  logic clk;
  logic rst_n;

  logic [1:0]        in_valid, in_ready, out_valid, out_ready;
  logic [1:0][2:0]   in_op;
  logic [1:0][31:0]  in_a, in_b, alu_a, alu_b, alu_f, alu_sum, out_result;
  logic [1:0]        alu_s1, alu_s2, alu_sub, alu_cin, alu_cout, alu_set;
  logic [1:0]        out_zero, out_cout, out_err;
  logic [1:0][15:0]  op_count;

  int n_chk  = 0;
  int n_fail = 0;
  int exp_cnt [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    alu_issue_stage #(.EXEC_CYCLES((g == 0) ? 1 : 4), .CNT_W(16)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid[g]), .in_ready(in_ready[g]), .in_op(in_op[g]),
      .in_a(in_a[g]), .in_b(in_b[g]),
      .alu_a(alu_a[g]), .alu_b(alu_b[g]), .alu_s1(alu_s1[g]), .alu_s2(alu_s2[g]),
      .alu_sub(alu_sub[g]), .alu_cin(alu_cin[g]),
      .alu_f(alu_f[g]), .alu_cout(alu_cout[g]), .alu_set(alu_set[g]),
      .out_valid(out_valid[g]), .out_ready(out_ready[g]),
      .out_result(out_result[g]), .out_zero(out_zero[g]), .out_cout(out_cout[g]),
      .out_err(out_err[g]), .op_count(op_count[g])
    );
    // ALU stub: adder always runs; in SLT mode f is the raw difference, not the set bit
    assign {alu_cout[g], alu_sum[g]} = {1'b0, alu_a[g]}
                                     + {1'b0, (alu_sub[g] ? ~alu_b[g] : alu_b[g])}
                                     + 33'(alu_sub[g]);
    assign alu_set[g] = $signed(alu_a[g]) < $signed(alu_b[g]);
    assign alu_f[g]   = alu_s1[g] ? alu_sum[g]
                                  : (alu_s2[g] ? (alu_a[g] | alu_b[g]) : (alu_a[g] & alu_b[g]));
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    int          bp;
    logic [31:0] r;
    logic        z;
    logic        c;
    logic        e;
  } vec_t;

  vec_t tbl [10];

  task automatic chk(input string nm, input int d, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d: got %0h expected %0h", nm, d, act, exp);
    end
  endtask

  function automatic int exec_of(input int d);
    return (d == 0) ? 1 : 4;
  endfunction

  // Opcode-level meaning of each operation; AND/OR carry comes from the adder's a+b
  function automatic void ref_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] r, output logic z, output logic c,
                                    output logic e);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    e = 1'b0;
    c = 1'b0;
    case (op)
      3'b000: begin r = a & b;      c = s[32]; end
      3'b010: begin r = a | b;      c = s[32]; end
      3'b100: begin r = s[31:0];    c = s[32]; end
      3'b101: begin r = a - b;      c = (a >= b); end
      3'b111: begin r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0; end
      default: begin r = '0;        e = 1'b1; end
    endcase
    z = (r == '0);
  endfunction

  task automatic run_op(input int d, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int bp, input logic [31:0] er,
                        input logic ez, input logic ec, input logic ee);
    logic [98:0] ctl_before;
    int lat;
    logic legal;
    legal = !ee;
    chk("idle_ready", d, {in_ready[d], out_valid[d]}, 2'b10);
    ctl_before = {alu_a[d], alu_b[d], alu_s1[d], alu_s2[d], alu_sub[d]};
    in_valid[d] = 1'b1; in_op[d] = op; in_a[d] = a; in_b[d] = b;
    @(posedge clk); #1;
    // keep junk requests asserted: they must be ignored until back in IDLE
    in_op[d] = 3'($urandom); in_a[d] = $urandom; in_b[d] = $urandom;
    if (legal)
      chk("alu_ctl", d, {alu_a[d], alu_b[d], alu_s1[d], alu_s2[d], alu_sub[d], alu_cin[d]},
          {a, b, op, 1'b0});
    else
      chk("alu_ctl_kept", d, {alu_a[d], alu_b[d], alu_s1[d], alu_s2[d], alu_sub[d]}, ctl_before);
    lat = 0;
    while (!out_valid[d] && lat < 40) begin
      chk("busy_not_ready", d, in_ready[d], 1'b0);
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", d, lat, legal ? exec_of(d) : 0);
    chk("result", d, out_result[d], er);
    chk("flags", d, {out_zero[d], out_cout[d], out_err[d], in_ready[d]}, {ez, ec, ee, 1'b0});
    for (int i = 0; i < bp; i++) begin
      @(posedge clk); #1;
      chk("hold", d, {out_valid[d], in_ready[d], out_result[d], out_zero[d], out_cout[d], out_err[d]},
          {1'b1, 1'b0, er, ez, ec, ee});
    end
    out_ready[d] = 1'b1;
    @(posedge clk); #1;
    out_ready[d] = 1'b0;
    in_valid[d]  = 1'b0;
    exp_cnt[d]++;
    chk("after_hs", d, {out_valid[d], in_ready[d], op_count[d]}, {1'b0, 1'b1, 16'(exp_cnt[d])});
  endtask

  function automatic logic [31:0] pick_val();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [2:0]  rop;
    logic [31:0] ra, rb, rr;
    logic        rz, rc, re;

    tbl[0] = '{3'b100, 32'd2,          32'd3,          0, 32'd5,          1'b0, 1'b0, 1'b0};
    tbl[1] = '{3'b101, 32'd3,          32'd3,          1, 32'd0,          1'b1, 1'b1, 1'b0};
    tbl[2] = '{3'b111, 32'd2,          32'd7,          0, 32'd1,          1'b0, 1'b0, 1'b0};
    tbl[3] = '{3'b010, 32'd4,          32'd5,          0, 32'd5,          1'b0, 1'b0, 1'b0};
    tbl[4] = '{3'b000, 32'd12,         32'd4,          6, 32'd4,          1'b0, 1'b0, 1'b0};
    tbl[5] = '{3'b011, 32'd9,          32'd9,          2, 32'd0,          1'b1, 1'b0, 1'b1};
    tbl[6] = '{3'b100, 32'hFFFF_FFFF,  32'd1,          0, 32'd0,          1'b1, 1'b1, 1'b0};
    tbl[7] = '{3'b101, 32'd0,          32'd1,          0, 32'hFFFF_FFFF,  1'b0, 1'b0, 1'b0};
    tbl[8] = '{3'b111, 32'h8000_0000,  32'd1,          0, 32'd1,          1'b0, 1'b0, 1'b0};
    tbl[9] = '{3'b111, 32'd1,          32'h8000_0000,  3, 32'd0,          1'b1, 1'b0, 1'b0};

    rst_n = 1'b0;
    in_valid = '0; out_ready = '0; in_op = '0; in_a = '0; in_b = '0;
    exp_cnt[0] = 0; exp_cnt[1] = 0;
    #12;
    for (int d = 0; d < 2; d++) begin
      chk("reset_hs", d, {in_ready[d], out_valid[d], op_count[d]}, {1'b1, 1'b0, 16'h0});
      chk("reset_regs", d, {out_result[d], out_zero[d], out_cout[d], out_err[d], alu_a[d], alu_b[d],
                            alu_s1[d], alu_s2[d], alu_sub[d], alu_cin[d]}, '0);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 10; i++)
        run_op(d, tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].bp, tbl[i].r, tbl[i].z, tbl[i].c, tbl[i].e);

    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 40; i++) begin
        rop = 3'($urandom);
        ra  = pick_val();
        rb  = (i % 5 == 0) ? ra : pick_val();
        ref_model(rop, ra, rb, rr, rz, rc, re);
        run_op(d, rop, ra, rb, $urandom_range(0, 3), rr, rz, rc, re);
      end

    // reset during EXEC of the 4-cycle instance abandons the operation
    in_valid[1] = 1'b1; in_op[1] = 3'b100; in_a[1] = 32'd50; in_b[1] = 32'd60;
    @(posedge clk); #1;
    in_valid[1] = 1'b0;
    @(posedge clk); #1;
    chk("mid_exec", 1, {in_ready[1], out_valid[1]}, 2'b00);
    rst_n = 1'b0;
    #1;
    for (int d = 0; d < 2; d++)
      chk("async_reset", d, {out_valid[d], in_ready[d], op_count[d], alu_a[d], out_result[d]},
          {1'b0, 1'b1, 16'h0, 32'h0, 32'h0});
    exp_cnt[0] = 0; exp_cnt[1] = 0;
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(1, 3'b100, 32'd1, 32'd1, 0, 32'd2, 1'b0, 1'b0, 1'b0);
    run_op(0, 3'b100, 32'd1, 32'd1, 0, 32'd2, 1'b0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
